// File: rtl/shift_arbiter_ctrl_if.sv
// -----------------------------------------------------------------------------
// shift_arbiter_ctrl_if
// Handshake and data bundle for shift_arbiter_ctrl.
//   Requester side (req0/req1): valid/ready handshake carrying an operand pair
//     A (data) and B (shift operand, shift amount = ~B).
//   Response side: valid/ready handshake returning the result, flags and the
//     ID of the owning requester.
//   Status: busy flag, completed-operation counter and overflow counter.
// Modports:
//   master - requesters and response consumer (drives the i_* signals)
//   slave  - the controller (drives the o_* signals)
// -----------------------------------------------------------------------------
interface shift_arbiter_ctrl_if #(
    parameter int BITS     = 32,
    parameter int CNT_BITS = 16
);
    logic                i_req0_valid;
    logic                o_req0_ready;
    logic [BITS-1:0]     i_req0_A;
    logic [BITS-1:0]     i_req0_B;
    logic                i_req1_valid;
    logic                o_req1_ready;
    logic [BITS-1:0]     i_req1_A;
    logic [BITS-1:0]     i_req1_B;
    logic                o_rsp_valid;
    logic                i_rsp_ready;
    logic                o_rsp_id;
    logic [BITS-1:0]     o_result;
    logic                o_error;
    logic                o_overflow;
    logic                o_busy;
    logic [CNT_BITS-1:0] o_op_cnt;
    logic [CNT_BITS-1:0] o_ovf_cnt;

    modport master (
        output i_req0_valid, i_req0_A, i_req0_B,
        output i_req1_valid, i_req1_A, i_req1_B,
        output i_rsp_ready,
        input  o_req0_ready, o_req1_ready,
        input  o_rsp_valid, o_rsp_id, o_result, o_error, o_overflow,
        input  o_busy, o_op_cnt, o_ovf_cnt
    );

    modport slave (
        input  i_req0_valid, i_req0_A, i_req0_B,
        input  i_req1_valid, i_req1_A, i_req1_B,
        input  i_rsp_ready,
        output o_req0_ready, o_req1_ready,
        output o_rsp_valid, o_rsp_id, o_result, o_error, o_overflow,
        output o_busy, o_op_cnt, o_ovf_cnt
    );
endinterface

// File: rtl/shift_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// shift_arbiter_ctrl
// Two-way round-robin arbiter and sequencer around a logical shift-right unit.
// One operation in flight: IDLE (grant/accept) -> EXEC (compute) -> RESP
// (hold response until consumed). Shift amount is ~B; amounts beyond BITS
// raise overflow and force the result to zero.
// Ports:
//   i_clk    - clock, rising edge
//   i_rst_n  - synchronous reset, active-low
//   bus      - shift_arbiter_ctrl_if.slave: requester handshakes, response
//              handshake, busy flag, op/overflow counters
// -----------------------------------------------------------------------------
module shift_arbiter_ctrl #(
    parameter int BITS     = 32,
    parameter int CNT_BITS = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    shift_arbiter_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [BITS-1:0]     SHIFT_MAX = BITS'(BITS);
    localparam logic [CNT_BITS-1:0] CNT_MAX   = '1;

    state_e              state_q, state_d;
    logic                rr_ptr_q, rr_ptr_d;      // requester favoured on a tie
    logic [BITS-1:0]     a_q, a_d;
    logic [BITS-1:0]     b_q, b_d;
    logic                id_q, id_d;              // owner of the in-flight op
    logic [BITS-1:0]     result_q, result_d;
    logic                ovf_q, ovf_d;
    logic [CNT_BITS-1:0] op_cnt_q, op_cnt_d;
    logic [CNT_BITS-1:0] ovf_cnt_q, ovf_cnt_d;

    logic                gnt1;
    logic                ready0, ready1;
    logic [BITS-1:0]     amt;
    logic [BITS-1:0]     shift_res;
    logic                shift_ovf;

    // Requester 1 wins when it is alone or when the pointer favours it.
    assign gnt1   = bus.i_req1_valid & (~bus.i_req0_valid | rr_ptr_q);
    assign ready0 = (state_q == IDLE) & bus.i_req0_valid & ~gnt1;
    assign ready1 = (state_q == IDLE) & gnt1;

    // Shift unit, fed only from the operand registers.
    assign amt = ~b_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch
        // can leave it unassigned and infer a latch.
        shift_res = '0;
        shift_ovf = 1'b0;
        if (amt > SHIFT_MAX) begin
            shift_ovf = 1'b1;
        end else if (amt != SHIFT_MAX) begin
            shift_res = a_q >> amt;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        a_d       = a_q;
        b_d       = b_q;
        id_d      = id_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        op_cnt_d  = op_cnt_q;
        ovf_cnt_d = ovf_cnt_q;

        case (state_q)
            IDLE: begin
                if (ready0) begin
                    a_d     = bus.i_req0_A;
                    b_d     = bus.i_req0_B;
                    id_d    = 1'b0;
                    state_d = EXEC;
                end else if (ready1) begin
                    a_d     = bus.i_req1_A;
                    b_d     = bus.i_req1_B;
                    id_d    = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = shift_res;
                ovf_d    = shift_ovf;
                state_d  = RESP;
            end
            RESP: begin
                if (bus.i_rsp_ready) begin
                    state_d  = IDLE;
                    rr_ptr_d = ~id_q;
                    op_cnt_d = op_cnt_q + CNT_BITS'(1);
                    if (ovf_q && (ovf_cnt_q != CNT_MAX)) begin
                        ovf_cnt_d = ovf_cnt_q + CNT_BITS'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        // Synchronous reset: every register, including the operand and
        // response registers, is cleared so nothing stale survives reset.
        if (!i_rst_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= 1'b0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            op_cnt_q  <= '0;
            ovf_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            id_q      <= id_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            op_cnt_q  <= op_cnt_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign bus.o_req0_ready = ready0;
    assign bus.o_req1_ready = ready1;
    assign bus.o_rsp_valid  = (state_q == RESP);
    assign bus.o_rsp_id     = id_q;
    assign bus.o_result     = result_q;
    assign bus.o_error      = 1'b0;   // amount is unsigned, nothing can be invalid
    assign bus.o_overflow   = ovf_q;
    assign bus.o_busy       = (state_q != IDLE);
    assign bus.o_op_cnt     = op_cnt_q;
    assign bus.o_ovf_cnt    = ovf_cnt_q;

endmodule
